fpu_status_accum: RTL and testbench



---
 rtl/fpu_status_accum.sv | 182 ++++++++++++++++++
 tb/tb_fpu_status_accum.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_status_accum.sv
// Sticky FPU exception-flag accumulator (fflags equivalent), with per-flag saturating event counters and a maskable trap request.
// Latency: 1 cycle. Every output is registered, so a result flag sampled at edge N is visible just after edge N.
// Backpressure: none. Every valid result channel is absorbed every cycle, and the block never stalls its producers.
//
// Ports:
//   clock, reset          single clock; synchronous active-high reset clears all state
//   resValid[NUM_CH]      per-channel result valid; flags of invalid channels are ignored
//   resFlags              channel c flags at [c*FLAG_W +: FLAG_W], bit order NV DZ OF UF NX (MSB..LSB)
//   clrReq                clear sticky flags and counters, then accumulate this cycle's flags
//   wrEn / wrData         software overwrite of the sticky flags (this cycle's flags still OR in)
//   trapMask              per-flag trap enable, applied to new events only
//   ackTrap               software acknowledge of an outstanding trap
//   stickyFlags           accumulated sticky flags
//   trapPending/trapCause trap request and the masked flags that raised it
//   eventCount            flag f counter at [f*CNT_W +: CNT_W]
module fpu_status_accum #(
  parameter int NUM_CH = 2,
  parameter int FLAG_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          resValid,
  input  logic [NUM_CH*FLAG_W-1:0]   resFlags,
  input  logic                       clrReq,
  input  logic                       wrEn,
  input  logic [FLAG_W-1:0]          wrData,
  input  logic [FLAG_W-1:0]          trapMask,
  input  logic                       ackTrap,
  output logic [FLAG_W-1:0]          stickyFlags,
  output logic                       trapPending,
  output logic [FLAG_W-1:0]          trapCause,
  output logic [FLAG_W*CNT_W-1:0]    eventCount
);

  // Per-flag increment can reach NUM_CH, so it needs enough bits for that value.
  localparam int INC_W = $clog2(NUM_CH + 1);
  // The adder is one bit wider than either operand so saturation is detected before any wrap.
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } trap_state_t;

  // ---------------------------------------------------------------------------
  // Gather this cycle's flags from the valid channels.
  // ---------------------------------------------------------------------------
  logic [FLAG_W-1:0] new_flags;
  logic [INC_W-1:0]  inc     [FLAG_W];

  always_comb begin
    new_flags = '0;
    for (int f = 0; f < FLAG_W; f++) begin
      inc[f] = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (resValid[c]) begin
        new_flags = new_flags | resFlags[c*FLAG_W +: FLAG_W];
        for (int f = 0; f < FLAG_W; f++) begin
          inc[f] = inc[f] + INC_W'(resFlags[c*FLAG_W + f]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a clear or a software write replaces the old value, but
  // flags arriving in the same cycle are always merged so no event is lost.
  // ---------------------------------------------------------------------------
  logic [FLAG_W-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | new_flags;
    if (clrReq) begin
      sticky_d = new_flags;
    end else if (wrEn) begin
      sticky_d = wrData | new_flags;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-flag saturating event counters. A clear restarts the count from this
  // cycle's increment. A software write of the flags leaves the counts alone.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q   [FLAG_W];
  logic [CNT_W-1:0] cnt_d   [FLAG_W];
  logic [SUM_W-1:0] cnt_sum [FLAG_W];

  always_comb begin
    for (int f = 0; f < FLAG_W; f++) begin
      cnt_sum[f] = (clrReq ? '0 : SUM_W'(cnt_q[f])) + SUM_W'(inc[f]);
      if (cnt_sum[f] > CNT_MAX) begin
        cnt_d[f] = '1;
      end else begin
        cnt_d[f] = cnt_sum[f][CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int f = 0; f < FLAG_W; f++) begin
        cnt_q[f] <= '0;
      end
    end else begin
      for (int f = 0; f < FLAG_W; f++) begin
        cnt_q[f] <= cnt_d[f];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Trap FSM. The cause is latched on entry and then frozen. Later trapping
  // flags only reach the sticky bits, unless they coincide with an acknowledge,
  // in which case they become the new trap. Clear and write never touch it.
  // The mask gates new events only, never sticky bits that are already set.
  // ---------------------------------------------------------------------------
  trap_state_t       state_q, state_d;
  logic [FLAG_W-1:0] cause_q, cause_d;
  logic [FLAG_W-1:0] trig;

  assign trig = new_flags & trapMask;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (trig != '0) begin
          state_d = PENDING;
          cause_d = trig;
        end
      end
      PENDING: begin
        if (ackTrap) begin
          if (trig != '0) begin
            cause_d = trig;
          end else begin
            state_d = IDLE;
            cause_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cause_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all driven straight from registers.
  // ---------------------------------------------------------------------------
  assign stickyFlags = sticky_q;
  assign trapPending = (state_q == PENDING);
  assign trapCause   = cause_q;

  for (genvar g = 0; g < FLAG_W; g++) begin : g_cnt_out
    assign eventCount[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_fpu_status_accum.sv
// Self-checking bench for fpu_status_accum: directed scenarios plus randomized traffic,
// compared against a flag/counter/trap reference model written from the block's rules.
module tb_fpu_status_accum;

  localparam int NUM_CH = 2;
  localparam int FLAG_W = 5;
  localparam int CNT_W  = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        resValid;
  logic [NUM_CH*FLAG_W-1:0] resFlags;
  logic                     clrReq;
  logic                     wrEn;
  logic [FLAG_W-1:0]        wrData;
  logic [FLAG_W-1:0]        trapMask;
  logic                     ackTrap;
  logic [FLAG_W-1:0]        stickyFlags;
  logic                     trapPending;
  logic [FLAG_W-1:0]        trapCause;
  logic [FLAG_W*CNT_W-1:0]  eventCount;

  fpu_status_accum #(
    .NUM_CH(NUM_CH),
    .FLAG_W(FLAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .resValid   (resValid),
    .resFlags   (resFlags),
    .clrReq     (clrReq),
    .wrEn       (wrEn),
    .wrData     (wrData),
    .trapMask   (trapMask),
    .ackTrap    (ackTrap),
    .stickyFlags(stickyFlags),
    .trapPending(trapPending),
    .trapCause  (trapCause),
    .eventCount (eventCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_sticky;
  int m_pending;
  int m_cause;
  int m_cnt [FLAG_W];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model one clock edge using the inputs currently applied.
  task automatic model_update();
    int nf;
    int trig;
    int incs [FLAG_W];
    if (reset) begin
      m_sticky  = 0;
      m_pending = 0;
      m_cause   = 0;
      for (int f = 0; f < FLAG_W; f++) m_cnt[f] = 0;
      return;
    end
    nf = 0;
    for (int f = 0; f < FLAG_W; f++) incs[f] = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (resValid[c]) begin
        nf = nf | int'(resFlags[c*FLAG_W +: FLAG_W]);
        for (int f = 0; f < FLAG_W; f++)
          if (resFlags[c*FLAG_W + f]) incs[f] = incs[f] + 1;
      end
    end
    if (clrReq)     m_sticky = nf;
    else if (wrEn)  m_sticky = int'(wrData) | nf;
    else            m_sticky = m_sticky | nf;
    for (int f = 0; f < FLAG_W; f++) begin
      int v;
      v = (clrReq ? 0 : m_cnt[f]) + incs[f];
      m_cnt[f] = (v > CNT_SAT) ? CNT_SAT : v;
    end
    trig = nf & int'(trapMask);
    if (m_pending == 0) begin
      if (trig != 0) begin
        m_pending = 1;
        m_cause   = trig;
      end
    end else if (ackTrap) begin
      if (trig != 0) begin
        m_cause = trig;
      end else begin
        m_pending = 0;
        m_cause   = 0;
      end
    end
  endtask

  task automatic check_all();
    check("sticky", stickyFlags, m_sticky);
    check("pending", trapPending, m_pending);
    check("cause", trapCause, m_cause);
    for (int f = 0; f < FLAG_W; f++)
      check($sformatf("cnt%0d", f), eventCount[f*CNT_W +: CNT_W], m_cnt[f]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    reset    = 1'b0;
    resValid = '0;
    resFlags = '0;
    clrReq   = 1'b0;
    wrEn     = 1'b0;
    wrData   = '0;
    ackTrap  = 1'b0;
  endtask

  task automatic set_ch(input logic [NUM_CH-1:0] v, input logic [FLAG_W-1:0] f0, input logic [FLAG_W-1:0] f1);
    resValid = v;
    resFlags = {f1, f0};
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int f);
    return eventCount[f*CNT_W +: CNT_W];
  endfunction

  initial begin
    set_idle();
    trapMask = '0;

    // Reset held two cycles with random inputs applied.
    for (int i = 0; i < 2; i++) begin
      reset    = 1'b1;
      resValid = NUM_CH'($urandom);
      resFlags = (NUM_CH*FLAG_W)'($urandom);
      clrReq   = 1'($urandom);
      wrEn     = 1'($urandom);
      wrData   = FLAG_W'($urandom);
      trapMask = FLAG_W'($urandom);
      ackTrap  = 1'($urandom);
      step();
    end
    check("rst_sticky", stickyFlags, 5'b00000);
    check("rst_pending", trapPending, 1'b0);
    check("rst_cause", trapCause, 5'b00000);
    check("rst_counts", eventCount, '0);

    // Two channels contribute in one cycle, then an invalid channel is ignored.
    set_idle();
    trapMask = '0;
    set_ch(2'b11, 5'b10000, 5'b01000);
    step();
    check("or_sticky", stickyFlags, 5'b11000);
    check("or_nv_cnt", cnt_of(4), 8'd1);
    check("or_dz_cnt", cnt_of(3), 8'd1);
    set_ch(2'b01, 5'b00000, 5'b11111);
    step();
    check("inv_sticky", stickyFlags, 5'b11000);
    check("inv_counts", eventCount, {8'd1, 8'd1, 8'd0, 8'd0, 8'd0});

    // Trap entry, frozen cause, acknowledge, and ack with a coincident new trap.
    trapMask = 5'b01000;
    set_ch(2'b01, 5'b01000, 5'b00000);
    step();
    check("trap_pend", trapPending, 1'b1);
    check("trap_cause", trapCause, 5'b01000);
    trapMask = 5'b11000;
    set_ch(2'b10, 5'b00000, 5'b10000);
    step();
    check("frozen_cause", trapCause, 5'b01000);
    check("frozen_sticky", stickyFlags, 5'b11000);
    set_ch(2'b00, 5'b00000, 5'b00000);
    ackTrap = 1'b1;
    step();
    check("ack_pend", trapPending, 1'b0);
    check("ack_cause", trapCause, 5'b00000);
    ackTrap = 1'b0;
    set_ch(2'b01, 5'b10000, 5'b00000);
    step();
    check("retrap_cause", trapCause, 5'b10000);
    ackTrap = 1'b1;
    set_ch(2'b01, 5'b01000, 5'b00000);
    step();
    check("ack_new_pend", trapPending, 1'b1);
    check("ack_new_cause", trapCause, 5'b01000);
    set_ch(2'b00, 5'b00000, 5'b00000);
    step();
    check("ack2_pend", trapPending, 1'b0);
    ackTrap = 1'b0;
    trapMask = '0;

    // Counter saturation: both channels raise NX for 130 cycles.
    set_ch(2'b11, 5'b00001, 5'b00001);
    for (int i = 0; i < 130; i++) step();
    check("sat_nx", cnt_of(0), 8'd255);
    for (int i = 0; i < 3; i++) step();
    check("sat_hold_nx", cnt_of(0), 8'd255);

    // Software write merged with a same-cycle event.
    set_ch(2'b10, 5'b00000, 5'b10000);
    wrEn   = 1'b1;
    wrData = 5'b00110;
    step();
    check("wr_sticky", stickyFlags, 5'b10110);
    wrEn = 1'b0;

    // Clear while a trap is pending, with a same-cycle NX event.
    trapMask = 5'b00001;
    set_ch(2'b01, 5'b00001, 5'b00000);
    step();
    check("pre_clr_pend", trapPending, 1'b1);
    clrReq = 1'b1;
    step();
    check("clr_sticky", stickyFlags, 5'b00001);
    check("clr_pend", trapPending, 1'b1);
    check("clr_cause", trapCause, 5'b00001);
    for (int f = 0; f < FLAG_W; f++)
      check($sformatf("clr_cnt%0d", f), cnt_of(f), (f == 0) ? 8'd1 : 8'd0);
    clrReq = 1'b0;

    // Reset asserted mid-trap.
    reset = 1'b1;
    step();
    check("midrst_pend", trapPending, 1'b0);
    check("midrst_sticky", stickyFlags, 5'b00000);
    check("midrst_counts", eventCount, '0);
    set_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      resValid = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++)
        resFlags[c*FLAG_W +: FLAG_W] = FLAG_W'($urandom) & FLAG_W'($urandom);
      clrReq   = ($urandom_range(0, 15) == 0);
      wrEn     = ($urandom_range(0, 9) == 0);
      wrData   = FLAG_W'($urandom);
      ackTrap  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) trapMask = FLAG_W'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
